// File: rtl/frame_wr_sched.sv
// Frame-level write scheduler: per frame, clears the write engine and then
// issues one write command per line into a ring of NUM_BUF frame buffers,
// skipping the buffer held by the reader.
module frame_wr_sched #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_BUF        = 3,
  parameter int unsigned LINE_W         = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cfg_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cfg_buf_stride,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cfg_line_stride,
  input  logic [31:0]               i_cfg_line_bytes,
  input  logic [LINE_W-1:0]         i_cfg_lines,
  input  logic                      i_frame_start,
  input  logic                      i_rd_lock,
  input  logic [2:0]                i_rd_buf_idx,
  output logic                      o_clr_vld,
  input  logic                      i_clr_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] o_ctrl_wr_addr,
  output logic [31:0]               o_ctrl_wr_b_len,
  output logic                      o_ctrl_wr_vld,
  input  logic                      i_ctrl_wr_rdy,
  input  logic [2:0]                i_err,
  output logic [2:0]                o_wr_buf_idx,
  output logic                      o_frame_done,
  output logic [2:0]                o_done_buf_idx,
  output logic                      o_busy,
  output logic [3:0]                o_err
);

  localparam logic [2:0] LastIdx = 3'(NUM_BUF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StClr,
    StIssue,
    StWaitDone,
    StFinish
  } state_e;

  state_e                    state_q, state_d;
  logic [2:0]                buf_idx_q, buf_idx_d;
  logic [AXI_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [LINE_W-1:0]         line_cnt_q, line_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AXI_ADDR_WIDTH-1:0] buf_stride_q, buf_stride_d;
  logic [AXI_ADDR_WIDTH-1:0] line_stride_q, line_stride_d;
  logic [31:0]               line_bytes_q, line_bytes_d;
  logic [LINE_W-1:0]         lines_q, lines_d;
  logic [3:0]                err_q, err_d;
  logic [2:0]                sel_idx;
  logic                      clr_vld, wr_vld, frame_done;

  function automatic logic [2:0] ring_inc(input logic [2:0] idx);
    return (idx == LastIdx) ? 3'd0 : idx + 3'd1;
  endfunction

  // Next ring slot, stepping over the buffer the reader currently holds.
  always_comb begin
    sel_idx = ring_inc(buf_idx_q);
    if (i_rd_lock && (sel_idx == i_rd_buf_idx)) begin
      sel_idx = ring_inc(sel_idx);
    end
  end

  // FSM next-state, datapath next-state and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    buf_idx_d     = buf_idx_q;
    line_addr_d   = line_addr_q;
    line_cnt_d    = line_cnt_q;
    base_d        = base_q;
    buf_stride_d  = buf_stride_q;
    line_stride_d = line_stride_q;
    line_bytes_d  = line_bytes_q;
    lines_d       = lines_q;
    clr_vld       = 1'b0;
    wr_vld        = 1'b0;
    frame_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_frame_start) begin
          base_d        = i_cfg_base_addr;
          buf_stride_d  = i_cfg_buf_stride;
          line_stride_d = i_cfg_line_stride;
          line_bytes_d  = i_cfg_line_bytes;
          lines_d       = i_cfg_lines;
          state_d       = StSel;
        end
      end
      StSel: begin
        buf_idx_d   = sel_idx;
        line_addr_d = base_q + AXI_ADDR_WIDTH'(sel_idx) * buf_stride_q;
        line_cnt_d  = '0;
        state_d     = StClr;
      end
      StClr: begin
        clr_vld = 1'b1;
        if (i_clr_rdy) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        wr_vld = 1'b1;
        if (i_ctrl_wr_rdy) begin
          line_addr_d = line_addr_q + line_stride_q;
          line_cnt_d  = line_cnt_q + LINE_W'(1);
          state_d     = StWaitDone;
        end
      end
      StWaitDone: begin
        // rdy here means the accepted line has been fully written.
        if (i_ctrl_wr_rdy) begin
          state_d = (line_cnt_q == lines_q) ? StFinish : StIssue;
        end
      end
      StFinish: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error accumulation; a start outside IDLE is flagged as an overrun.
  always_comb begin
    err_d = {err_q[3] | (i_frame_start & (state_q != StIdle)), err_q[2:0] | i_err};
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      buf_idx_q     <= LastIdx;
      line_addr_q   <= '0;
      line_cnt_q    <= '0;
      base_q        <= '0;
      buf_stride_q  <= '0;
      line_stride_q <= '0;
      line_bytes_q  <= '0;
      lines_q       <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      buf_idx_q     <= buf_idx_d;
      line_addr_q   <= line_addr_d;
      line_cnt_q    <= line_cnt_d;
      base_q        <= base_d;
      buf_stride_q  <= buf_stride_d;
      line_stride_q <= line_stride_d;
      line_bytes_q  <= line_bytes_d;
      lines_q       <= lines_d;
      err_q         <= err_d;
    end
  end

  assign o_clr_vld       = clr_vld;
  assign o_ctrl_wr_vld   = wr_vld;
  assign o_ctrl_wr_addr  = line_addr_q;
  assign o_ctrl_wr_b_len = line_bytes_q;
  assign o_wr_buf_idx    = buf_idx_q;
  assign o_frame_done    = frame_done;
  assign o_done_buf_idx  = frame_done ? buf_idx_q : 3'd0;
  assign o_busy          = (state_q != StIdle);
  assign o_err           = err_q;

endmodule

// File: tb/tb_frame_wr_sched.sv
// Scoreboard bench for frame_wr_sched: stimulus pushes expected commands and
// frame completions; a monitor pops and compares on every DUT handshake.
module tb_frame_wr_sched;

  localparam int unsigned AW = 32;
  localparam int unsigned NB = 3;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_base, cfg_buf_stride, cfg_line_stride;
  logic [31:0]   cfg_line_bytes;
  logic [LW-1:0] cfg_lines;
  logic          frame_start, rd_lock;
  logic [2:0]    rd_buf_idx;
  logic          clr_vld, clr_rdy;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_b_len;
  logic          wr_vld, wr_rdy;
  logic [2:0]    err_in;
  logic [2:0]    wr_buf_idx;
  logic          frame_done;
  logic [2:0]    done_buf_idx;
  logic          busy;
  logic [3:0]    err_out;

  always #5 clk = ~clk;

  frame_wr_sched #(
    .AXI_ADDR_WIDTH(AW),
    .NUM_BUF       (NB),
    .LINE_W        (LW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cfg_base_addr  (cfg_base),
    .i_cfg_buf_stride (cfg_buf_stride),
    .i_cfg_line_stride(cfg_line_stride),
    .i_cfg_line_bytes (cfg_line_bytes),
    .i_cfg_lines      (cfg_lines),
    .i_frame_start    (frame_start),
    .i_rd_lock        (rd_lock),
    .i_rd_buf_idx     (rd_buf_idx),
    .o_clr_vld        (clr_vld),
    .i_clr_rdy        (clr_rdy),
    .o_ctrl_wr_addr   (wr_addr),
    .o_ctrl_wr_b_len  (wr_b_len),
    .o_ctrl_wr_vld    (wr_vld),
    .i_ctrl_wr_rdy    (wr_rdy),
    .i_err            (err_in),
    .o_wr_buf_idx     (wr_buf_idx),
    .o_frame_done     (frame_done),
    .o_done_buf_idx   (done_buf_idx),
    .o_busy           (busy),
    .o_err            (err_out)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] blen;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] lines;
  } done_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int cmd_total = 0;
  int cmd_in_frame = 0;
  int clr_in_frame = 0;

  // Engine model knobs.
  int clr_delay   = 0;
  int stall_delay = 0;
  int busy_delay  = 2;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic miss(input string name);
    checks++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Write engine model: decides its ready lines at negedge, applies after posedge.
  initial begin
    int   clr_cnt;
    int   busy_cnt;
    int   stall_cnt;
    logic nclr, nrdy;
    clr_cnt = 0;
    busy_cnt = 0;
    stall_cnt = 0;
    clr_rdy = 1'b0;
    wr_rdy  = 1'b1;
    forever begin
      @(negedge clk);
      nclr = 1'b0;
      nrdy = wr_rdy;
      if (!rst_n) begin
        clr_cnt = 0;
        busy_cnt = 0;
        stall_cnt = 0;
        nrdy = (stall_delay == 0);
      end else begin
        if (clr_vld && clr_rdy) clr_cnt = 0;
        else if (clr_vld) begin
          if (clr_cnt >= clr_delay) nclr = 1'b1;
          else clr_cnt++;
        end
        if (wr_vld && wr_rdy) begin
          busy_cnt  = busy_delay;
          stall_cnt = 0;
          nrdy      = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          nrdy = (busy_cnt == 0);
        end else if (wr_vld) begin
          if (stall_cnt >= stall_delay) nrdy = 1'b1;
          else begin
            stall_cnt++;
            nrdy = 1'b0;
          end
        end else begin
          nrdy = (stall_delay == 0);
        end
      end
      @(posedge clk);
      #2;
      clr_rdy = nclr;
      wr_rdy  = nrdy;
    end
  end

  // Monitor: compares handshakes and frame completions against the scoreboard.
  initial begin
    logic          pend, cpend;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_blen;
    cmd_t          c;
    done_t         d;
    pend  = 1'b0;
    cpend = 1'b0;
    p_addr = '0;
    p_blen = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend  = 1'b0;
        cpend = 1'b0;
      end else begin
        if (pend) chk("cmd held under backpressure", {wr_vld, wr_addr, wr_b_len},
                      {1'b1, p_addr, p_blen});
        if (cpend) chk("clr_vld held under backpressure", clr_vld, 1'b1);
        pend   = wr_vld && !wr_rdy;
        p_addr = wr_addr;
        p_blen = wr_b_len;
        cpend  = clr_vld && !clr_rdy;
        if (clr_vld && clr_rdy) clr_in_frame++;
        if (wr_vld && wr_rdy) begin
          cmd_total++;
          cmd_in_frame++;
          if (exp_cmd_q.size() == 0) miss("unexpected command");
          else begin
            c = exp_cmd_q.pop_front();
            chk("cmd addr", wr_addr, c.addr);
            chk("cmd b_len", wr_b_len, c.blen);
          end
        end
        if (frame_done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) miss("unexpected frame_done");
          else begin
            d = exp_done_q.pop_front();
            chk("done_buf_idx", done_buf_idx, d.idx);
            chk("commands per frame", cmd_in_frame, d.lines);
            chk("clears per frame", clr_in_frame, 1);
          end
          cmd_in_frame = 0;
          clr_in_frame = 0;
        end
      end
    end
  end

  // Push expectations for one frame and pulse frame start.
  task automatic start_frame(input logic [2:0] idx, input logic [31:0] first_addr,
                             input logic [15:0] lines);
    cmd_t  c;
    done_t d;
    cfg_lines = lines;
    for (int i = 0; i < int'(lines); i++) begin
      c.addr = first_addr + 32'(i) * cfg_line_stride;
      c.blen = cfg_line_bytes;
      exp_cmd_q.push_back(c);
    end
    d.idx   = idx;
    d.lines = lines;
    exp_done_q.push_back(d);
    @(posedge clk);
    #2 frame_start = 1'b1;
    @(posedge clk);
    #2 frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == start; i++) @(posedge clk);
    chk("frame completed in time", done_cnt != start, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("reset clr_vld", clr_vld, 1'b0);
    chk("reset wr_vld", wr_vld, 1'b0);
    chk("reset wr_addr", wr_addr, 32'h0);
    chk("reset b_len", wr_b_len, 32'h0);
    chk("reset frame_done", frame_done, 1'b0);
    chk("reset done_buf_idx", done_buf_idx, 3'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset err", err_out, 4'h0);
    chk("reset wr_buf_idx", wr_buf_idx, 3'd2);
  endtask

  initial begin
    int base_cmds;
    rst_n           = 1'b0;
    frame_start     = 1'b0;
    rd_lock         = 1'b0;
    rd_buf_idx      = 3'd0;
    err_in          = 3'd0;
    cfg_base        = 32'h1000_0000;
    cfg_buf_stride  = 32'h0010_0000;
    cfg_line_stride = 32'h0000_1000;
    cfg_line_bytes  = 32'd3840;
    cfg_lines       = 16'd4;
    repeat (3) @(posedge clk);
    #2 chk_reset_outputs();
    rst_n = 1'b1;

    // Basic frame plus rotation through the ring.
    start_frame(3'd0, 32'h1000_0000, 16'd4);
    wait_done();
    start_frame(3'd1, 32'h1010_0000, 16'd4);
    wait_done();
    start_frame(3'd2, 32'h1020_0000, 16'd4);
    wait_done();
    start_frame(3'd0, 32'h1000_0000, 16'd4);
    wait_done();

    // Reader holds buffer 1: ring steps from 0 straight to 2.
    #2 rd_lock = 1'b1;
    rd_buf_idx = 3'd1;
    start_frame(3'd2, 32'h1020_0000, 16'd2);
    wait_done();
    #2 rd_lock = 1'b0;
    rd_buf_idx = 3'd0;

    // Slow engine: delayed clear, stalled commands, long line writes.
    clr_delay   = 5;
    stall_delay = 3;
    busy_delay  = 20;
    start_frame(3'd0, 32'h1000_0000, 16'd3);
    wait_done();
    clr_delay   = 0;
    stall_delay = 0;
    busy_delay  = 2;

    // Overrun start and an engine error while a frame is in flight.
    start_frame(3'd1, 32'h1010_0000, 16'd4);
    repeat (4) @(posedge clk);
    #2 frame_start = 1'b1;
    err_in = 3'b010;
    @(posedge clk);
    #2 frame_start = 1'b0;
    err_in = 3'b000;
    wait_done();
    chk("sticky err after frame", err_out, 4'b1010);
    repeat (3) @(posedge clk);
    #2 chk("sticky err later", err_out, 4'b1010);

    // Reset while line 2 is being written.
    base_cmds = cmd_total;
    start_frame(3'd2, 32'h1020_0000, 16'd4);
    for (int i = 0; i < 500 && cmd_total < base_cmds + 2; i++) @(posedge clk);
    chk("second line issued before reset", cmd_total - base_cmds, 2);
    #2 rst_n = 1'b0;
    exp_cmd_q.delete();
    exp_done_q.delete();
    cmd_in_frame = 0;
    clr_in_frame = 0;
    @(posedge clk);
    #2 chk_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cfg_line_bytes = 32'd1920;
    start_frame(3'd0, 32'h1000_0000, 16'd2);
    wait_done();

    repeat (3) @(posedge clk);
    chk("no leftover commands", exp_cmd_q.size(), 0);
    chk("no leftover frames", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
